muldiv_unit: RTL and testbench
==============================

# muldiv_unit

EX-stage multiply/divide unit of the P6 five-stage MIPS pipeline. Consumes the decoded `MULDIVMode`/`HILOSel` from the controller and the forwarded rs/rt operands, and holds the architectural HI/LO registers. Models multi-cycle latency with a busy counter. Produces `Start`/`Busy`, which the hazard unit uses to stall any MULDIV-type instruction in ID, and `MULDIVOut` for mfhi/mflo write-back.

## Interface
- `MULT_CYCLES`, default 5: Busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: Busy cycles for div/divu.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `MULDIVMode` in 4: EX-stage operation code from the shared constants (NOTHING, MULT, MULTU, DIV, DIVU, MTHI, MTLO).
- `HILOSel` in 1: 1 selects HI (MULDIV_HIGH) and 0 selects LO (MULDIV_LOW) for `MULDIVOut`.
- `A` in 32: forwarded rs value.
- `B` in 32: forwarded rt value.
- `Start` out 1: combinational. High while `MULDIVMode` is MULT, MULTU, DIV or DIVU and `Busy`=0.
- `Busy` out 1: registered. High during the operation's latency window.
- `HI` out 32: architectural HI register.
- `LO` out 32: architectural LO register.
- `MULDIVOut` out 32: combinational, `HILOSel ? HI : LO`.

## Operation
- State: `HI`, `LO`, `Busy`, 4-bit down-counter `cnt`, pending result registers `pHI`/`pLO`, and a `pend_valid` flag.
- Two states:
  - IDLE (`Busy`=0).
  - RUN (`Busy`=1).
- IDLE, Start cycle:
  - At the edge, latch the result into `pHI`/`pLO`.
  - Load `cnt` = MULT_CYCLES or DIV_CYCLES.
  - Set `Busy`=1 and go to RUN.
- RUN: decrement `cnt` each edge. On the edge where `cnt`==1:
  - Commit `pHI`/`pLO` to `HI`/`LO`.
  - Clear `Busy` and return to IDLE.
- MULT: {HI,LO} = signed(A)*signed(B), 64-bit.
- MULTU: {HI,LO} = A*B, unsigned 64-bit.
- DIV: LO = quotient truncated toward zero; HI = remainder, which takes the dividend's sign.
- DIVU: unsigned quotient and remainder.
- Divide by zero (B==0):
  - Busy timing is unchanged.
  - HI and LO keep their prior values.
  - No X is ever produced.
- MTHI/MTLO in IDLE: HI or LO takes A at the next edge, with zero latency. `Start` and `Busy` are unaffected.
- Any mode arriving during RUN is ignored, including MTHI/MTLO. The hazard unit stalls these in ID, so this case is defensive.
- NOTHING: no state change.
- `MULDIVOut` always shows the committed HI/LO. It never shows pending results.

## Timing
- Reset values: `HI`=0, `LO`=0, `Busy`=0, `cnt`=0, `pHI`/`pLO`=0. `Start` follows its inputs combinationally.
- Reset asserted mid-RUN aborts immediately: the pending result is discarded and HI/LO are cleared.
- Start is in cycle T:
  - `Busy`=1 for cycles T+1 … T+N, where N = MULT_CYCLES or DIV_CYCLES.
  - New HI/LO are visible in cycle T+N+1, the same cycle `Busy` drops.
- A Start in cycle T+N+1 (back-to-back) is legal. It re-enters RUN at the next edge.
- Simultaneous MTHI/MTLO and Start cannot occur, because an instruction has exactly one mode.
- A pipeline stall or flush of the EX stage is handled upstream by injecting NOTHING. A mult/div that has already started always completes.

## Structure
- The shared constants header (name.v) owns:
  - MULDIVMode codes: NOTHING=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - MULDIV_HIGH=1 and MULDIV_LOW=0.
  - Default latencies, 5 and 10.
- Single module with no sub-module. The arithmetic is behavioural (`*`, `/`, `%` with `$signed`), and the 64-bit product goes into a local wire.

## Test plan
- MULT A=0xFFFFFFFE(-2), B=3 -> Start=1 in cycle T; Busy high T+1..T+5; in T+6, HI=0xFFFFFFFF and LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=2 -> after 5 Busy cycles, HI=0x00000001 and LO=0xFFFFFFFE; MULDIVOut tracks HILOSel.
- DIV A=0xFFFFFFF9(-7), B=2 -> Busy for 10 cycles; then LO=0xFFFFFFFD and HI=0xFFFFFFFF. DIVU with the same operands -> LO=0x7FFFFFFC, HI=1.
- MTHI A=0x12345678 in IDLE -> HI=0x12345678 the next cycle; Busy stays 0. MTLO issued while Busy -> LO unchanged.
- DIV with B=0 after LO=0xAAAA5555 -> Busy for 10 cycles, then LO still 0xAAAA5555 and HI unchanged.
- reset=0 at the 3rd Busy cycle of a MULT -> Busy=0 and HI=LO=0 immediately, with no later commit. Back-to-back MULT starting in the Busy-drop cycle completes correctly.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: operation codes,
// HI/LO select values, default latencies and the signed/unsigned divide helpers.
package muldiv_unit_pkg;

  typedef enum logic [3:0] {
    NOTHING = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MTHI    = 4'd5,
    MTLO    = 4'd6
  } muldiv_mode_e;

  localparam logic MULDIV_HIGH = 1'b1;
  localparam logic MULDIV_LOW  = 1'b0;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // Signed divide via magnitudes so the INT_MIN / -1 corner never traps;
  // quotient truncates toward zero and the remainder follows the dividend.
  function automatic hilo_t sdivmod(input logic [31:0] a, input logic [31:0] b);
    hilo_t       res;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] q;
    logic [31:0] r;
    ua = a[31] ? (~a + 32'd1) : a;
    ub = b[31] ? (~b + 32'd1) : b;
    if (ub == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if (a[31] ^ b[31]) q = ~q + 32'd1;
    if (a[31])         r = ~r + 32'd1;
    res.hi = r;
    res.lo = q;
    return res;
  endfunction

  function automatic hilo_t udivmod(input logic [31:0] a, input logic [31:0] b);
    hilo_t res;
    if (b == 32'd0) begin
      res.hi = 32'd0;
      res.lo = 32'd0;
    end else begin
      res.hi = a % b;
      res.lo = a / b;
    end
    return res;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit: owns architectural HI/LO, computes the result
// at Start and commits it after a fixed busy window.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MULDIVMode,
  input  logic        HILOSel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MULDIVOut
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  md_state_e    state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [31:0]  hi_q, hi_d;
  logic [31:0]  lo_q, lo_d;
  logic [31:0]  phi_q, phi_d;
  logic [31:0]  plo_q, plo_d;
  logic         pend_valid_q, pend_valid_d;

  muldiv_mode_e mode;
  logic         is_md;
  logic         is_div;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  hilo_t              div_s;
  hilo_t              div_u;
  hilo_t              start_res;

  assign mode   = muldiv_mode_e'(MULDIVMode);
  assign is_div = (mode == DIV) || (mode == DIVU);
  assign is_md  = (mode == MULT) || (mode == MULTU) || is_div;

  assign Busy      = (state_q == ST_RUN);
  assign Start     = is_md && !Busy;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign MULDIVOut = (HILOSel == MULDIV_HIGH) ? hi_q : lo_q;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign div_s  = sdivmod(A, B);
  assign div_u  = udivmod(A, B);

  always_comb begin
    start_res = '0;
    case (mode)
      MULT:    start_res = hilo_t'(prod_s);
      MULTU:   start_res = hilo_t'(prod_u);
      DIV:     start_res = div_s;
      DIVU:    start_res = div_u;
      default: start_res = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    phi_d        = phi_q;
    plo_d        = plo_q;
    pend_valid_d = pend_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          phi_d        = start_res.hi;
          plo_d        = start_res.lo;
          // A divide by zero still burns its latency but must not commit.
          pend_valid_d = !(is_div && (B == 32'd0));
          cnt_d        = is_div ? DIV_LOAD : MULT_LOAD;
          state_d      = ST_RUN;
        end else if (mode == MTHI) begin
          hi_d = A;
        end else if (mode == MTLO) begin
          lo_d = A;
        end
      end
      ST_RUN: begin
        // <=1 also terminates a window configured with a zero latency.
        if (cnt_q <= 4'd1) begin
          if (pend_valid_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
          pend_valid_d = 1'b0;
          cnt_d        = 4'd0;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      phi_q        <= 32'd0;
      plo_q        <= 32'd0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      phi_q        <= phi_d;
      plo_q        <= plo_d;
      pend_valid_q <= pend_valid_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: randomized and directed operations checked
// against a 64-bit arithmetic reference model of HI/LO.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  MULDIVMode = 4'd0;
  logic        HILOSel = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  wire         Start;
  wire         Busy;
  wire  [31:0] HI;
  wire  [31:0] LO;
  wire  [31:0] MULDIVOut;

  muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MULDIVMode(MULDIVMode), .HILOSel(HILOSel),
    .A(A), .B(B), .Start(Start), .Busy(Busy), .HI(HI), .LO(LO),
    .MULDIVOut(MULDIVOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;
  logic [31:0] prev_hi = 32'd0;
  logic [31:0] prev_lo = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: results from the arithmetic definition on 64-bit integers.
  task automatic model_exec(input logic [3:0] mode, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (mode)
      4'd1: begin sp = sa * sb; mhi = sp[63:32]; mlo = sp[31:0]; end
      4'd2: begin up = ua * ub; mhi = up[63:32]; mlo = up[31:0]; end
      4'd3: if (b != 0) begin sq = sa / sb; sr = sa % sb; mlo = sq[31:0]; mhi = sr[31:0]; end
      4'd4: if (b != 0) begin uq = ua / ub; ur = ua % ub; mlo = uq[31:0]; mhi = ur[31:0]; end
      4'd5: mhi = a;
      4'd6: mlo = a;
      default: ;
    endcase
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (Busy && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (Busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s wait_idle: Busy still 1 after %0d cycles, required 0", tag, k);
    end
  endtask

  task automatic op(input logic [3:0] mode, input logic [31:0] a, input logic [31:0] b,
                    input string tag);
    bit   md;
    exp_t e;
    md = (mode >= 4'd1) && (mode <= 4'd4);
    wait_idle(tag);
    prev_hi = mhi;
    prev_lo = mlo;
    MULDIVMode = mode;
    A = a;
    B = b;
    HILOSel = 1'($urandom_range(0, 1));
    @(negedge clk);
    check({tag, " Start"}, {31'd0, Start}, md ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    MULDIVMode = 4'd0;
    model_exec(mode, a, b);
    if (md) begin
      e.hi  = mhi;
      e.lo  = mlo;
      e.n   = (mode <= 4'd2) ? 5 : 10;
      e.tag = tag;
      exp_q.push_back(e);
    end else if (mode == 4'd5 || mode == 4'd6) begin
      check({tag, " mt HI"}, HI, mhi);
      check({tag, " mt LO"}, LO, mlo);
      check({tag, " mt Busy"}, {31'd0, Busy}, 32'd0);
    end
  endtask

  // Drive a mode during the first busy cycle; it must be ignored.
  task automatic busy_poke(input logic [3:0] mode, input logic [31:0] a, input string tag);
    MULDIVMode = mode;
    A = a;
    B = $urandom;
    @(negedge clk);
    check({tag, " poke Start"}, {31'd0, Start}, 32'd0);
    @(posedge clk); #1;
    MULDIVMode = 4'd0;
    check({tag, " poke HI"}, HI, prev_hi);
    check({tag, " poke LO"}, LO, prev_lo);
    check({tag, " poke Busy"}, {31'd0, Busy}, 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every falling edge of Busy is a commit; pop and compare.
  initial begin
    int   bc;
    logic prev;
    exp_t e;
    bc = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        bc = 0;
        prev = 1'b0;
      end else begin
        if (Busy) begin
          bc++;
        end else if (prev) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL commit: Busy dropped with no pending op, got HI=0x%08h LO=0x%08h", HI, LO);
          end else begin
            e = exp_q.pop_front();
            check({e.tag, " HI"}, HI, e.hi);
            check({e.tag, " LO"}, LO, e.lo);
            check({e.tag, " busy cycles"}, 32'(bc), 32'(e.n));
            check({e.tag, " MULDIVOut"}, MULDIVOut, HILOSel ? e.hi : e.lo);
          end
          bc = 0;
        end
        prev = Busy;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got %0d tests, required completion", n_tests);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  m;
    logic [31:0] ra, rb;
    // Reset state; Start is combinational even while reset is held.
    #12;
    check("reset Busy", {31'd0, Busy}, 32'd0);
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);
    check("reset MULDIVOut", MULDIVOut, 32'd0);
    check("reset Start idle", {31'd0, Start}, 32'd0);
    MULDIVMode = 4'd1;
    #1;
    check("reset Start comb", {31'd0, Start}, 32'd1);
    MULDIVMode = 4'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    op(4'd1, 32'hFFFF_FFFE, 32'd3, "mult -2*3");
    wait_idle("mult -2*3");
    check("mult -2*3 HI const", HI, 32'hFFFF_FFFF);
    check("mult -2*3 LO const", LO, 32'hFFFF_FFFA);

    op(4'd2, 32'hFFFF_FFFF, 32'd2, "multu");
    wait_idle("multu");
    HILOSel = 1'b1; #1;
    check("multu out HI", MULDIVOut, 32'h0000_0001);
    HILOSel = 1'b0; #1;
    check("multu out LO", MULDIVOut, 32'hFFFF_FFFE);

    op(4'd3, 32'hFFFF_FFF9, 32'd2, "div -7/2");
    wait_idle("div -7/2");
    check("div LO const", LO, 32'hFFFF_FFFD);
    check("div HI const", HI, 32'hFFFF_FFFF);
    op(4'd4, 32'hFFFF_FFF9, 32'd2, "divu");

    op(4'd5, 32'h1234_5678, 32'd0, "mthi");
    op(4'd1, 32'd7, 32'd9, "mult poke");
    busy_poke(4'd6, 32'hDEAD_BEEF, "mtlo busy");
    op(4'd6, 32'hAAAA_5555, 32'd0, "mtlo");
    op(4'd3, 32'h0000_1234, 32'd0, "div by 0");
    wait_idle("div by 0");
    check("div0 LO const", LO, 32'hAAAA_5555);

    // Reset in the third busy cycle aborts with no later commit.
    op(4'd1, 32'h0001_0000, 32'h0001_0000, "mult reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    mhi = 32'd0;
    mlo = 32'd0;
    #1;
    check("abort Busy", {31'd0, Busy}, 32'd0);
    check("abort HI", HI, 32'd0);
    check("abort LO", LO, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("abort late HI", HI, 32'd0);
    check("abort late LO", LO, 32'd0);

    // Back-to-back: the second op issues in the Busy-drop cycle.
    op(4'd1, 32'h8000_0000, 32'h8000_0000, "b2b 1");
    op(4'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, "b2b 2");

    for (int i = 0; i < 150; i++) begin
      m  = 4'($urandom_range(1, 6));
      ra = pick();
      rb = pick();
      op(m, ra, rb, $sformatf("rnd%0d m%0d", i, m));
      if (m <= 4'd4 && $urandom_range(0, 3) == 0)
        busy_poke(4'($urandom_range(1, 6)), $urandom, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) begin
        wait_idle("rnd gap");
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    wait_idle("final");
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
